// File: rtl/pll_reconfig_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_seq_pkg
//  Description : Shared types and constants for the PLL reconfiguration
//                sequencer: profile and FSM state encodings, fractional K
//                words and pll_cfg register addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reconfig_seq_pkg;

    // Clock profile selected by the OSD status bits; NONE means nothing applied
    typedef enum logic [1:0] {
        PROF_PAL  = 2'd0,
        PROF_NTSC = 2'd1,
        PROF_BUS  = 2'd2,
        PROF_NONE = 2'd3
    } profile_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MODE      = 3'd1,
        ST_KFRAC     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // Fractional K words for the three target output frequencies
    localparam logic [31:0] K_PAL  = 32'd1503512573;  // 31.527954 MHz
    localparam logic [31:0] K_NTSC = 32'd3357876127;  // 32.727266 MHz
    localparam logic [31:0] K_BUS  = 32'd2233385555;  // 32.000000 MHz

    // pll_cfg management register addresses
    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_KFRAC = 6'd7;

    // Business mode wins over the video standard bit
    function automatic profile_e select_profile(input logic model, input logic ntsc);
        if (model)
            return PROF_BUS;
        else if (ntsc)
            return PROF_NTSC;
        else
            return PROF_PAL;
    endfunction

    // K word for a profile; NONE never reaches the KFRAC write
    function automatic logic [31:0] k_word(input profile_e p);
        case (p)
            PROF_PAL:  return K_PAL;
            PROF_NTSC: return K_NTSC;
            PROF_BUS:  return K_BUS;
            default:   return 32'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_seq_if
//  Description : Avalon-MM write-only management link to the pll_cfg block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_reconfig_seq_if;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/pll_reconfig_seq_sync_stable.sv
`default_nettype none
// ============================================================================
//  Module      : sync_stable
//  Description : Two-flop synchroniser followed by a stability filter. The
//                output follows the input only after STABLE_CYCLES consecutive
//                equal synchronised samples; o_valid rises on first acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_stable #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic CLK_50M,
    input  logic RESET,
    input  logic i_async,
    output logic o_stable,
    output logic o_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_cand;
    logic [CW-1:0] r_cnt;

    // Synchronise, then count consecutive equal samples and accept at the limit
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_cand   <= 1'b0;
            r_cnt    <= '0;
            o_stable <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            if (r_sync != r_cand) begin
                r_cand <= r_sync;
                r_cnt  <= CW'(1);
            end else if (r_cnt != CW'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                o_stable <= r_cand;
                o_valid  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_seq
//  Description : Retunes the fractional-N system PLL (K word only) to the PAL,
//                NTSC or Business profile whenever the filtered OSD selection
//                changes, and holds the core in reset until the PLL relocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq
    import pll_reconfig_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 2_000_000,
    parameter bit FORCE_INIT    = 1'b1
) (
    input  logic                      CLK_50M,
    input  logic                      RESET,
    input  logic                      model,
    input  logic                      ntsc,
    input  logic                      pll_locked,
    pll_reconfig_seq_if.master        mgmt,
    output logic                      busy,
    output logic                      core_hold,
    output logic                      lock_err
);

    // Lock indication is unreliable right after START, so it is ignored this long
    localparam int LOCK_IGNORE = 64;

    logic     w_model;
    logic     w_model_vld;
    logic     w_ntsc;
    logic     w_ntsc_vld;
    logic     w_sel_vld;
    logic     w_sel_event;
    profile_e w_sel;

    logic        r_lock_meta;
    logic        r_lock_sync;
    state_e      r_state;
    profile_e    r_applied;
    profile_e    r_lat_sel;
    profile_e    r_sel_prev;
    logic        r_sel_vld_d;
    logic        r_pending;
    logic [31:0] r_timer;

    sync_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync_model (
        .CLK_50M  (CLK_50M),
        .RESET    (RESET),
        .i_async  (model),
        .o_stable (w_model),
        .o_valid  (w_model_vld)
    );

    sync_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync_ntsc (
        .CLK_50M  (CLK_50M),
        .RESET    (RESET),
        .i_async  (ntsc),
        .o_stable (w_ntsc),
        .o_valid  (w_ntsc_vld)
    );

    assign w_sel_vld = w_model_vld & w_ntsc_vld;
    assign w_sel     = select_profile(w_model, w_ntsc);
    // An event is the first valid selection or any change of the decoded profile;
    // ntsc toggling under model=1 decodes to the same profile and is no event
    assign w_sel_event = w_sel_vld && (!r_sel_vld_d || (w_sel != r_sel_prev));

    // Lock is only a level; a plain two-flop synchroniser is enough
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Trigger tracking plus the reconfiguration sequence with registered outputs
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state             <= ST_IDLE;
            r_applied           <= PROF_NONE;
            r_lat_sel           <= PROF_NONE;
            r_sel_prev          <= PROF_NONE;
            r_sel_vld_d         <= 1'b0;
            r_pending           <= FORCE_INIT;
            r_timer             <= 32'd0;
            mgmt.mgmt_write     <= 1'b0;
            mgmt.mgmt_address   <= 6'd0;
            mgmt.mgmt_writedata <= 32'd0;
            busy                <= 1'b0;
            core_hold           <= 1'b0;
            lock_err            <= 1'b0;
        end else begin
            r_sel_prev  <= w_sel;
            r_sel_vld_d <= w_sel_vld;

            // Without a forced init the power-up PLL setting is taken as correct
            if (!FORCE_INIT && w_sel_vld && !r_sel_vld_d && (r_applied == PROF_NONE))
                r_applied <= w_sel;
            else if (w_sel_event && (w_sel != r_applied))
                r_pending <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_pending && w_sel_vld) begin
                        r_state             <= ST_MODE;
                        r_pending           <= 1'b0;
                        r_lat_sel           <= w_sel;
                        busy                <= 1'b1;
                        core_hold           <= 1'b1;
                        mgmt.mgmt_write     <= 1'b1;
                        mgmt.mgmt_address   <= REG_MODE;
                        mgmt.mgmt_writedata <= 32'd0;
                    end
                end

                // Each write state: hold until accepted, idle one cycle, then advance
                ST_MODE: begin
                    if (mgmt.mgmt_write) begin
                        if (!mgmt.mgmt_waitrequest)
                            mgmt.mgmt_write <= 1'b0;
                    end else begin
                        r_state             <= ST_KFRAC;
                        mgmt.mgmt_write     <= 1'b1;
                        mgmt.mgmt_address   <= REG_KFRAC;
                        mgmt.mgmt_writedata <= k_word(r_lat_sel);
                    end
                end

                ST_KFRAC: begin
                    if (mgmt.mgmt_write) begin
                        if (!mgmt.mgmt_waitrequest)
                            mgmt.mgmt_write <= 1'b0;
                    end else begin
                        r_state             <= ST_START;
                        mgmt.mgmt_write     <= 1'b1;
                        mgmt.mgmt_address   <= REG_START;
                        mgmt.mgmt_writedata <= 32'd0;
                    end
                end

                ST_START: begin
                    if (mgmt.mgmt_write) begin
                        if (!mgmt.mgmt_waitrequest)
                            mgmt.mgmt_write <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT_LOCK;
                        r_timer <= 32'd0;
                    end
                end

                // A timeout gives up without retrying; core_hold stays asserted
                // because the PLL output cannot be trusted
                ST_WAIT_LOCK: begin
                    if ((r_timer >= 32'(LOCK_IGNORE)) && r_lock_sync) begin
                        r_state <= ST_DONE;
                    end else if (r_timer == 32'(LOCK_TIMEOUT)) begin
                        r_state   <= ST_IDLE;
                        r_applied <= PROF_NONE;
                        lock_err  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end

                // Commit the latched profile; a selection that moved meanwhile re-pends
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_applied <= r_lat_sel;
                    r_pending <= w_sel_vld && (w_sel != r_lat_sel);
                    lock_err  <= 1'b0;
                    busy      <= 1'b0;
                    core_hold <= 1'b0;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reconfig_seq
//  Description : Directed self-checking bench for the PLL reconfig sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;
    import pll_reconfig_seq_pkg::*;

    localparam int C_LOCK_TO = 1000;

    logic CLK_50M    = 1'b0;
    logic RESET      = 1'b1;
    logic model      = 1'b0;
    logic ntsc       = 1'b0;
    logic pll_locked = 1'b0;
    logic busy;
    logic core_hold;
    logic lock_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [5:0]  wa [0:63];
    logic [31:0] wd [0:63];

    pll_reconfig_seq_if bus ();

    pll_reconfig_seq #(
        .STABLE_CYCLES (16),
        .LOCK_TIMEOUT  (C_LOCK_TO),
        .FORCE_INIT    (1'b1)
    ) dut (
        .CLK_50M    (CLK_50M),
        .RESET      (RESET),
        .model      (model),
        .ntsc       (ntsc),
        .pll_locked (pll_locked),
        .mgmt       (bus.master),
        .busy       (busy),
        .core_hold  (core_hold),
        .lock_err   (lock_err)
    );

    always #10 CLK_50M = ~CLK_50M;

    // Log every accepted management write
    always @(posedge CLK_50M) begin
        if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
            if (wr_cnt < 64) begin
                wa[wr_cnt] <= bus.mgmt_address;
                wd[wr_cnt] <= bus.mgmt_writedata;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_50M);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n;
        n = 0;
        while (wr_cnt < target && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_writes_seen"}, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_kfrac(input string tag);
        int n;
        n = 0;
        while (!(bus.mgmt_write && bus.mgmt_address == REG_KFRAC) && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_kfrac_seen"}, 32'(bus.mgmt_write), 32'd1);
    endtask

    // Full sequence: three writes, lock after 100 cycles, release
    task automatic run_seq(input logic [31:0] k, input string tag);
        int base;
        base = wr_cnt;
        wait_writes(base + 3, tag);
        chk({tag, "_w0_addr"}, 32'(wa[base]),     32'd0);
        chk({tag, "_w0_data"}, wd[base],          32'd0);
        chk({tag, "_w1_addr"}, 32'(wa[base + 1]), 32'd7);
        chk({tag, "_w1_data"}, wd[base + 1],      k);
        chk({tag, "_w2_addr"}, 32'(wa[base + 2]), 32'd2);
        chk({tag, "_w2_data"}, wd[base + 2],      32'd0);
        tick(100);
        chk({tag, "_hold_waiting"}, 32'(core_hold), 32'd1);
        pll_locked = 1'b1;
        wait_idle(200, tag);
        tick(1);
        chk({tag, "_hold_released"}, 32'(core_hold), 32'd0);
        chk({tag, "_lock_err"},      32'(lock_err),  32'd0);
        chk({tag, "_write_count"},   32'(wr_cnt - base), 32'd3);
    endtask

    initial begin
        int base;
        bus.mgmt_waitrequest = 1'b0;

        // Reset state
        tick(3);
        chk("rst_write",     32'(bus.mgmt_write),   32'd0);
        chk("rst_addr",      32'(bus.mgmt_address), 32'd0);
        chk("rst_data",      bus.mgmt_writedata,    32'd0);
        chk("rst_busy",      32'(busy),             32'd0);
        chk("rst_core_hold", 32'(core_hold),        32'd0);
        chk("rst_lock_err",  32'(lock_err),         32'd0);
        RESET = 1'b0;

        // 1: forced initial PAL sequence
        run_seq(K_PAL, "t1");
        chk("t1_applied", 32'(dut.r_applied), 32'(PROF_PAL));

        // 2: NTSC change, then a short glitch that must be filtered
        pll_locked = 1'b0;
        ntsc = 1'b1;
        run_seq(K_NTSC, "t2");
        chk("t2_applied", 32'(dut.r_applied), 32'(PROF_NTSC));
        base = wr_cnt;
        ntsc = 1'b0;
        tick(5);
        ntsc = 1'b1;
        tick(60);
        chk("t2_glitch_writes", 32'(wr_cnt - base), 32'd0);
        chk("t2_glitch_busy",   32'(busy),          32'd0);

        // 3: Business mode; ntsc toggles underneath must not retrigger
        pll_locked = 1'b0;
        model = 1'b1;
        run_seq(K_BUS, "t3");
        chk("t3_applied", 32'(dut.r_applied), 32'(PROF_BUS));
        base = wr_cnt;
        ntsc = 1'b0;
        tick(40);
        ntsc = 1'b1;
        tick(40);
        ntsc = 1'b0;
        tick(40);
        chk("t3_toggle_writes", 32'(wr_cnt - base), 32'd0);
        chk("t3_toggle_busy",   32'(busy),          32'd0);

        // 4: waitrequest stalls the KFRAC write for 10 cycles
        pll_locked = 1'b0;
        base = wr_cnt;
        model = 1'b0;
        wait_kfrac("t4");
        bus.mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t4_hold_write", 32'(bus.mgmt_write),   32'd1);
            chk("t4_hold_addr",  32'(bus.mgmt_address), 32'd7);
            chk("t4_hold_data",  bus.mgmt_writedata,    K_PAL);
        end
        chk("t4_stall_count", 32'(wr_cnt - base), 32'd1);
        bus.mgmt_waitrequest = 1'b0;
        wait_writes(base + 3, "t4");
        chk("t4_kfrac_data", wd[base + 1], K_PAL);
        chk("t4_start_addr", 32'(wa[base + 2]), 32'd2);
        pll_locked = 1'b1;
        wait_idle(200, "t4");
        chk("t4_write_count", 32'(wr_cnt - base), 32'd3);
        chk("t4_applied",     32'(dut.r_applied), 32'(PROF_PAL));

        // 5: lock never comes -> timeout; next selection recovers
        pll_locked = 1'b0;
        base = wr_cnt;
        ntsc = 1'b1;
        wait_writes(base + 3, "t5a");
        chk("t5a_kfrac_data", wd[base + 1], K_NTSC);
        tick(20);
        chk("t5a_err_before", 32'(lock_err), 32'd0);
        wait_idle(C_LOCK_TO + 200, "t5a");
        chk("t5a_lock_err", 32'(lock_err),       32'd1);
        chk("t5a_applied",  32'(dut.r_applied),  32'(PROF_NONE));
        tick(60);
        chk("t5a_no_retry", 32'(wr_cnt - base), 32'd3);
        base = wr_cnt;
        ntsc = 1'b0;
        wait_writes(base + 3, "t5b");
        chk("t5b_kfrac_data", wd[base + 1], K_PAL);
        tick(20);
        chk("t5b_err_sticky", 32'(lock_err), 32'd1);
        pll_locked = 1'b1;
        wait_idle(200, "t5b");
        tick(1);
        chk("t5b_err_cleared", 32'(lock_err),      32'd0);
        chk("t5b_applied",     32'(dut.r_applied), 32'(PROF_PAL));

        // 6: reset during a stalled KFRAC write restarts from MODE
        pll_locked = 1'b0;
        ntsc = 1'b1;
        wait_kfrac("t6");
        bus.mgmt_waitrequest = 1'b1;
        tick(2);
        RESET = 1'b1;
        tick(1);
        chk("t6_rst_write",   32'(bus.mgmt_write), 32'd0);
        chk("t6_rst_busy",    32'(busy),           32'd0);
        chk("t6_rst_applied", 32'(dut.r_applied),  32'(PROF_NONE));
        tick(2);
        RESET = 1'b0;
        bus.mgmt_waitrequest = 1'b0;
        run_seq(K_NTSC, "t6");
        chk("t6_applied", 32'(dut.r_applied), 32'(PROF_NTSC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
